fft_stage_sequencer: RTL

Control FSM for the 32-point radix-2 DIT FFT. It walks the 5 stages × 16 butterflies in order. For each butterfly it issues the two operand addresses and the twiddle index k of W32^k, which selects the entry in the real/imaginary twiddle ROMs. It uses a valid/ready handshake toward the butterfly datapath and inserts a programmable flush gap between stages so in-place write-back completes before the next stage reads.

---
 rtl/fft_stage_sequencer_if.sv | 25 ++
 rtl/fft_stage_sequencer.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/fft_stage_sequencer_if.sv
// Command bus between the FFT stage sequencer and the butterfly datapath:
// start/ready toward the sequencer, butterfly command fields and status back.
interface fft_stage_sequencer_if;
    logic       start;
    logic       bf_ready;
    logic       bf_valid;
    logic [2:0] stage;
    logic [3:0] bf_idx;
    logic [4:0] addr_a;
    logic [4:0] addr_b;
    logic [3:0] tw_idx;
    logic       stage_done;
    logic       busy;
    logic       done;

    modport master (
        input  start, bf_ready,
        output bf_valid, stage, bf_idx, addr_a, addr_b, tw_idx, stage_done, busy, done
    );

    modport slave (
        output start, bf_ready,
        input  bf_valid, stage, bf_idx, addr_a, addr_b, tw_idx, stage_done, busy, done
    );
endinterface

// File: rtl/fft_stage_sequencer.sv
// Control FSM for a 32-point radix-2 DIT FFT: walks 5 stages x 16 butterflies,
// issuing operand addresses and twiddle index, with a flush gap between stages.
module fft_stage_sequencer #(
    parameter int PIPE_LAT = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    fft_stage_sequencer_if.master bus
);

    typedef enum logic [1:0] {IDLE, ISSUE, FLUSH, DONE} state_t;

    localparam bit         HAS_FLUSH  = (PIPE_LAT > 0);
    localparam logic [3:0] FLUSH_LAST = (PIPE_LAT > 0) ? 4'(PIPE_LAT - 1) : 4'd0;

    // Returns {addr_a, addr_b, tw_idx} for stage s, butterfly j.
    function automatic logic [13:0] bf_addr(input logic [2:0] s, input logic [3:0] j);
        logic [4:0] span;
        logic [3:0] mask;
        logic [3:0] grp;
        logic [3:0] pos;
        logic [4:0] a;
        logic [3:0] tw;
        span = 5'd1 << s;
        mask = 4'(span - 5'd1);
        grp  = j >> s;
        pos  = j & mask;
        a    = ({1'b0, grp} << (s + 3'd1)) + {1'b0, pos};
        tw   = pos << (3'd4 - s);
        return {a, a + span, tw};
    endfunction

    state_t     state_q, state_d;
    logic [2:0] s_q, s_d;
    logic [3:0] j_q, j_d;
    logic [3:0] cnt_q, cnt_d;
    logic       bf_valid_q, bf_valid_d;
    logic [4:0] addr_a_q, addr_a_d;
    logic [4:0] addr_b_q, addr_b_d;
    logic [3:0] tw_q, tw_d;
    logic       stage_done_q, stage_done_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic       accept;

    assign accept = bf_valid_q & bus.bf_ready;

    always_comb begin
        state_d      = state_q;
        s_d          = s_q;
        j_d          = j_q;
        cnt_d        = cnt_q;
        stage_done_d = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d = ISSUE;
                    s_d     = 3'd0;
                    j_d     = 4'd0;
                end
            end
            ISSUE: begin
                if (accept) begin
                    if (j_q != 4'd15) begin
                        j_d = j_q + 4'd1;
                    end else begin
                        stage_done_d = 1'b1;
                        if (HAS_FLUSH) begin
                            state_d = FLUSH;
                            cnt_d   = 4'd0;
                        end else if (s_q == 3'd4) begin
                            state_d = DONE;
                        end else begin
                            s_d = s_q + 3'd1;
                            j_d = 4'd0;
                        end
                    end
                end
            end
            FLUSH: begin
                if (cnt_q == FLUSH_LAST) begin
                    if (s_q == 3'd4) begin
                        state_d = DONE;
                    end else begin
                        state_d = ISSUE;
                        s_d     = s_q + 3'd1;
                        j_d     = 4'd0;
                    end
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            DONE: begin
                state_d = IDLE;
                s_d     = 3'd0;
                j_d     = 4'd0;
            end
            default: state_d = IDLE;
        endcase

        // Outputs are registered from the next-state view so they line up with state_q.
        {addr_a_d, addr_b_d, tw_d} = (state_d == IDLE) ? 14'd0 : bf_addr(s_d, j_d);
        bf_valid_d = (state_d == ISSUE);
        busy_d     = (state_d != IDLE);
        done_d     = (state_d == DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            s_q          <= 3'd0;
            j_q          <= 4'd0;
            cnt_q        <= 4'd0;
            bf_valid_q   <= 1'b0;
            addr_a_q     <= 5'd0;
            addr_b_q     <= 5'd0;
            tw_q         <= 4'd0;
            stage_done_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            s_q          <= s_d;
            j_q          <= j_d;
            cnt_q        <= cnt_d;
            bf_valid_q   <= bf_valid_d;
            addr_a_q     <= addr_a_d;
            addr_b_q     <= addr_b_d;
            tw_q         <= tw_d;
            stage_done_q <= stage_done_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    assign bus.bf_valid   = bf_valid_q;
    assign bus.stage      = s_q;
    assign bus.bf_idx     = j_q;
    assign bus.addr_a     = addr_a_q;
    assign bus.addr_b     = addr_b_q;
    assign bus.tw_idx     = tw_q;
    assign bus.stage_done = stage_done_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;

endmodule
